// File: rtl/add_arb_pkg.sv
// Shared defaults and helpers for the add_arb shared-adder arbiter.
package add_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/add_arb_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the search starts at ptr+1,
// isolate the lowest set bit, then rotate the one-hot grant back into place.
module rr_arbiter
  import add_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic [W-1:0] start;
  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;

  always_comb begin
    start   = (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
    rot_req = N'({req, req} >> start);
    // Two's-complement trick keeps only the lowest set request bit.
    rot_gnt = rot_req & (~rot_req + N'(1));
    gnt     = N'(({rot_gnt, rot_gnt} << start) >> N);
  end

endmodule

// File: rtl/add_arb.sv
// One registered adder shared by NUM_REQ requesters under round-robin arbitration.
// Optional build macro ADD_ARB_CARRY_EN adds a registered rsp_carry output.
module add_arb
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 2,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic [ID_W-1:0]           rsp_id
`ifdef ADD_ARB_CARRY_EN
  ,
  output logic                      rsp_carry
`endif
);

  localparam int PTR_W = clog2_min1(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("add_arb: NUM_REQ must be within 2..8");
  end
  if (ID_W < clog2_min1(NUM_REQ)) begin : g_bad_id_w
    $error("add_arb: ID_W too narrow for NUM_REQ");
  end

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   win_idx;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic               cap;
  logic               accept;
`ifdef ADD_ARB_CARRY_EN
  logic [DATA_W:0]    sum_next;
`else
  logic [DATA_W-1:0]  sum_next;
`endif

  rr_arbiter #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // The result slot can take a new sum when empty or draining this cycle.
  always_comb begin
    cap       = !rsp_valid || rsp_ready;
    req_ready = cap ? gnt : '0;
    accept    = |req_ready;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_idx = PTR_W'(i);
    end
    a_sel = req_a[win_idx*DATA_W +: DATA_W];
    b_sel = req_b[win_idx*DATA_W +: DATA_W];
`ifdef ADD_ARB_CARRY_EN
    sum_next = {1'b0, a_sel} + {1'b0, b_sel};
`else
    sum_next = a_sel + b_sel;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      ptr       <= PTR_W'(NUM_REQ - 1);
`ifdef ADD_ARB_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_next[DATA_W-1:0];
      rsp_id    <= ID_W'(win_idx);
      ptr       <= win_idx;
`ifdef ADD_ARB_CARRY_EN
      rsp_carry <= sum_next[DATA_W];
`endif
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
